// File: rtl/mips32_pipe_fwd_if.sv
// Bus bundle for mips32_pipe_fwd: instruction-memory preload port,
// debug register read port and core status (pc, halted, retired).
interface mips32_pipe_fwd_if #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int IMEM_DEPTH = 1024
);
    localparam int PA = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(NREGS);

    logic            imem_we;
    logic [PA-1:0]   imem_waddr;
    logic [31:0]     imem_wdata;
    logic [RW-1:0]   dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic [PA-1:0]   pc;
    logic            halted;
    logic [31:0]     retired;

    modport master (
        output imem_we, imem_waddr, imem_wdata, dbg_raddr,
        input  dbg_rdata, pc, halted, retired
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, dbg_raddr,
        output dbg_rdata, pc, halted, retired
    );
endinterface

// File: rtl/mips32_pipe_fwd.sv
// 5-stage MIPS32-subset pipeline (IF/ID/EX/MEM/WB) with EX forwarding,
// single-cycle load-use interlock, EX-resolved branches and HLT freeze.
module mips32_pipe_fwd #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    mips32_pipe_fwd_if.slave bus
);
    localparam int PA = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(NREGS);
    localparam int DA = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef struct packed {
        logic            valid;
        logic [5:0]      op;
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
        logic [RW-1:0]   dest;
        logic            wen;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [PA-1:0]   npc;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      op;
        logic [RW-1:0]   dest;
        logic            wen;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      op;
        logic [RW-1:0]   dest;
        logic            wen;
        logic [XLEN-1:0] alu;
    } mem_wb_t;

    logic [31:0]     imem_q [IMEM_DEPTH];
    logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
    logic [XLEN-1:0] dmem_rdata_q;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_view [NREGS];

    logic [PA-1:0]   pc_q, pc_d;
    logic            if_id_valid_q;
    logic [31:0]     if_id_ir_q;
    logic [PA-1:0]   if_id_npc_q;
    id_ex_t          id_ex_q, id_ex_d;
    ex_mem_t         ex_mem_q;
    mem_wb_t         mem_wb_q;
    logic            hlt_pending_q, hlt_pending_d;
    logic            halted_q;
    logic [31:0]     retired_q;

    // Decode of the instruction sitting in IF/ID
    logic [5:0]      id_opc;
    logic [RW-1:0]   id_rs, id_rt, id_rd;
    logic [XLEN-1:0] id_imm;
    logic            id_is_rr, id_is_rm, id_is_lw, id_is_sw, id_is_br, id_is_hlt;

    assign id_opc    = if_id_ir_q[31:26];
    assign id_rs     = if_id_ir_q[21 +: RW];
    assign id_rt     = if_id_ir_q[16 +: RW];
    assign id_rd     = if_id_ir_q[11 +: RW];
    assign id_imm    = XLEN'($signed(if_id_ir_q[15:0]));
    assign id_is_rr  = (id_opc <= OP_MUL);
    assign id_is_rm  = (id_opc == OP_ADDI) || (id_opc == OP_SUBI) || (id_opc == OP_SLTI);
    assign id_is_lw  = (id_opc == OP_LW);
    assign id_is_sw  = (id_opc == OP_SW);
    assign id_is_br  = (id_opc == OP_BNEQZ) || (id_opc == OP_BEQZ);
    assign id_is_hlt = !(id_is_rr || id_is_rm || id_is_lw || id_is_sw || id_is_br);

    logic            wb_wen;
    logic [XLEN-1:0] wb_value;
    assign wb_value = (mem_wb_q.op == OP_LW) ? dmem_rdata_q : mem_wb_q.alu;
    assign wb_wen   = mem_wb_q.valid && mem_wb_q.wen && !halted_q;

    // Write-first register view: the value WB is writing this cycle wins
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf_view
            if (gi == 0) begin : g_zero
                assign rf_view[gi] = '0;
            end else begin : g_reg
                assign rf_view[gi] = (wb_wen && mem_wb_q.dest == RW'(gi)) ? wb_value : rf_q[gi];
            end
        end
    endgenerate

    logic [XLEN-1:0] ex_a, ex_b, ex_alu;
    logic            br_taken;
    logic [PA-1:0]   br_target;
    logic            stall, id_hlt, fetch_stop;

    assign br_target = id_ex_q.npc + id_ex_q.imm[PA-1:0];

    always_comb begin
        ex_a = id_ex_q.a;
        if (ex_mem_q.valid && ex_mem_q.wen && ex_mem_q.op != OP_LW && ex_mem_q.dest == id_ex_q.rs)
            ex_a = ex_mem_q.alu;
        else if (mem_wb_q.valid && mem_wb_q.wen && mem_wb_q.dest == id_ex_q.rs)
            ex_a = wb_value;
        ex_b = id_ex_q.b;
        if (ex_mem_q.valid && ex_mem_q.wen && ex_mem_q.op != OP_LW && ex_mem_q.dest == id_ex_q.rt)
            ex_b = ex_mem_q.alu;
        else if (mem_wb_q.valid && mem_wb_q.wen && mem_wb_q.dest == id_ex_q.rt)
            ex_b = wb_value;
        case (id_ex_q.op)
            OP_ADD:                ex_alu = ex_a + ex_b;
            OP_SUB:                ex_alu = ex_a - ex_b;
            OP_AND:                ex_alu = ex_a & ex_b;
            OP_OR:                 ex_alu = ex_a | ex_b;
            OP_SLT:                ex_alu = ($signed(ex_a) < $signed(ex_b)) ? XLEN'(1) : '0;
            OP_MUL:                ex_alu = ex_a * ex_b;
            OP_LW, OP_SW, OP_ADDI: ex_alu = ex_a + id_ex_q.imm;
            OP_SUBI:               ex_alu = ex_a - id_ex_q.imm;
            OP_SLTI:               ex_alu = ($signed(ex_a) < $signed(id_ex_q.imm)) ? XLEN'(1) : '0;
            default:               ex_alu = '0;
        endcase
        br_taken = id_ex_q.valid &&
                   ((id_ex_q.op == OP_BEQZ && ex_a == '0) || (id_ex_q.op == OP_BNEQZ && ex_a != '0));
    end

    assign stall = if_id_valid_q && id_ex_q.valid && id_ex_q.op == OP_LW && id_ex_q.wen &&
                   (id_ex_q.dest == id_rs || id_ex_q.dest == id_rt);
    assign id_hlt     = if_id_valid_q && id_is_hlt;
    assign fetch_stop = id_hlt || hlt_pending_q;

    always_comb begin
        id_ex_d = '0;
        if (if_id_valid_q && !br_taken && !stall) begin
            id_ex_d.valid = 1'b1;
            id_ex_d.op    = id_is_hlt ? OP_HLT : id_opc;
            id_ex_d.rs    = id_rs;
            id_ex_d.rt    = id_rt;
            id_ex_d.dest  = id_is_rr ? id_rd : id_rt;
            id_ex_d.wen   = (id_is_rr || id_is_rm || id_is_lw) && ((id_is_rr ? id_rd : id_rt) != '0);
            id_ex_d.a     = rf_view[id_rs];
            id_ex_d.b     = rf_view[id_rt];
            id_ex_d.imm   = id_imm;
            id_ex_d.npc   = if_id_npc_q;
        end
    end

    // A taken branch overrides both the interlock and a younger HLT in ID
    always_comb begin
        pc_d          = pc_q;
        hlt_pending_d = hlt_pending_q;
        if (br_taken)
            pc_d = br_target;
        else if (!stall && !fetch_stop)
            pc_d = pc_q + PA'(1);
        if (id_hlt && !br_taken && !stall)
            hlt_pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            if_id_valid_q <= 1'b0;
            if_id_npc_q   <= '0;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
            hlt_pending_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
        end else if (!halted_q) begin
            pc_q           <= pc_d;
            hlt_pending_q  <= hlt_pending_d;
            id_ex_q        <= id_ex_d;
            ex_mem_q.valid <= id_ex_q.valid;
            ex_mem_q.op    <= id_ex_q.op;
            ex_mem_q.dest  <= id_ex_q.dest;
            ex_mem_q.wen   <= id_ex_q.wen;
            ex_mem_q.alu   <= ex_alu;
            ex_mem_q.sdata <= ex_b;
            mem_wb_q.valid <= ex_mem_q.valid;
            mem_wb_q.op    <= ex_mem_q.op;
            mem_wb_q.dest  <= ex_mem_q.dest;
            mem_wb_q.wen   <= ex_mem_q.wen;
            mem_wb_q.alu   <= ex_mem_q.alu;
            if (br_taken || (!stall && fetch_stop)) begin
                if_id_valid_q <= 1'b0;
            end else if (!stall) begin
                if_id_valid_q <= 1'b1;
                if_id_npc_q   <= pc_q + PA'(1);
            end
            if (mem_wb_q.valid)
                retired_q <= retired_q + 32'd1;
            if (mem_wb_q.valid && mem_wb_q.op == OP_HLT)
                halted_q <= 1'b1;
        end
    end

    // Instruction RAM: read-old on same-address write, fetch register held on stall
    always_ff @(posedge clk) begin
        if (bus.imem_we)
            imem_q[bus.imem_waddr] <= bus.imem_wdata;
        if (!halted_q && !stall)
            if_id_ir_q <= imem_q[pc_q];
    end

    logic [DA-1:0] mem_addr;
    logic          dmem_we;
    assign mem_addr = ex_mem_q.alu[DA-1:0];
    assign dmem_we  = ex_mem_q.valid && ex_mem_q.op == OP_SW && !halted_q && !rst;

    always_ff @(posedge clk) begin
        if (dmem_we)
            dmem_q[mem_addr] <= ex_mem_q.sdata;
        dmem_rdata_q <= dmem_q[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else if (wb_wen) begin
            rf_q[mem_wb_q.dest] <= wb_value;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.retired   = retired_q;
    assign bus.dbg_rdata = rf_view[bus.dbg_raddr];
endmodule

// File: doc/mips32_pipe_fwd.md
# mips32_pipe_fwd

Parametrised single-clock 5-stage MIPS32-subset pipeline (IF, ID, EX, MEM, WB) with full operand forwarding, load-use interlock, taken-branch flush and synchronous reset. It succeeds the two-phase MIPS32 core as the team's CPU block. Data width, register count and memory depths are generic. Instruction memory is preloadable through a write port, and register state is observable through a debug read port.

## Interface
- XLEN, 32, datapath/register/data-memory word width; legal range 16..64.
- NREGS, 32, architectural registers; power of two, 2..32; reg fields use low log2(NREGS) bits.
- IMEM_DEPTH, 1024, instruction words (32-bit each), word-addressed.
- DMEM_DEPTH, 1024, data words (XLEN each), word-addressed.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_we  in  1  instruction-memory write enable.
- imem_waddr  in  clog2(IMEM_DEPTH)  write address.
- imem_wdata  in  32  instruction word.
- dbg_raddr  in  clog2(NREGS)  debug register select.
- dbg_rdata  out  XLEN  combinational read of register dbg_raddr, post-write value.
- pc  out  clog2(IMEM_DEPTH)  current fetch address.
- halted  out  1  HLT has retired; pipeline frozen.
- retired  out  32  count of instructions written back (bubbles excluded).

## Operation
- Opcodes [31:26]: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111. Any other opcode is treated as HLT.
- Fields: rs [25:21], rt [20:16], rd [15:11], imm [15:0].
  - RR ops write rd.
  - RM ops and LW write rt.
  - SW stores rt to DMEM[rs+imm].
- Arithmetic:
  - imm is sign-extended to XLEN.
  - ADD/SUB/MUL results keep the low XLEN bits.
  - SLT/SLTI use a signed compare; the result is 1 or 0.
  - Memory address is the low clog2(DMEM_DEPTH) bits of rs+imm; the upper bits are ignored.
- R0 reads as 0. Writes to R0 are discarded and are never a forwarding source.
- Register file is write-first: a WB write and an ID read of the same register in one cycle return the new value.
- Forwarding into EX, priority EX/MEM over MEM/WB, for both rs and rt (including the SW store data).
- Load-use: if the instruction in EX is LW with dest equal to rs or rt of the instruction in ID (dest nonzero), then PC and IF/ID hold and a bubble is inserted into EX. Exactly 1 stall cycle.
- Branches resolve in EX.
  - Target = NPC + imm, where NPC = branch PC + 1, truncated to the PC width.
  - BEQZ is taken if rs == 0. BNEQZ is taken if rs != 0. rs comes from the forwarded value.
  - On a taken branch: PC loads the target; IF/ID and ID/EX become bubbles. Penalty is 2 cycles.
  - A not-taken branch costs nothing.
- HLT:
  - When HLT is decoded in ID, fetch stops and PC holds. Younger slots fill with bubbles.
  - Older instructions complete.
  - When HLT reaches WB: halted is set, retired counts the HLT, and all state is frozen until rst.
  - A HLT flushed by a taken branch has no effect.
- IMEM writes are accepted in any cycle. A fetch from the same address in the same cycle returns the old word.

## Timing
- Reset values:
  - pc=0, halted=0, retired=0.
  - All pipeline registers hold bubbles.
  - All registers are 0.
  - IMEM and DMEM contents are retained.
- Cycle 0 is the first cycle with rst low; it fetches IMEM[0].
- Without stalls, instruction k writes back at the edge ending cycle k+4. Throughput is 1 instruction per cycle.
- Each load-use stall delays all younger instructions by 1 cycle. Each taken branch delays them by 2 cycles.
- rst asserted mid-program takes effect at the next edge. In-flight instructions are discarded: no register, DMEM or retired update from them. Execution restarts at IMEM[0].
- rst dominates all other events in the same cycle.

## Test plan
- Forwarding chain: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; HLT.
  - Expect R3=30, R4=20, no stalls.
  - halted rises after the edge ending cycle 8; retired=5.
- Load-use: ADDI R1,R0,7; SW R1,4(R0); LW R2,4(R0); ADD R3,R2,R2; HLT.
  - Expect DMEM[4]=7, R3=14, and exactly one stall: halted one cycle later than the stall-free count; retired=5.
- Branch loop: ADDI R1,R0,3; then loop SUBI R1,R1,1; BNEQZ R1,-2; then ADDI R5,R0,9; HLT.
  - Expect R1=0, R5=9, retired=9.
  - The 2 taken branches each add 2 cycles.
  - Instructions on the not-taken fall-through path are never written back.
- R0/SLT edge: ADDI R0,R0,5; SUBI R1,R0,1; SLT R2,R1,R0; SLTI R3,R0,-1; HLT.
  - Expect R0=0, R1=all ones, R2=1, R3=0.
- Reset mid-run:
  - Run the branch loop and assert rst for 1 cycle after 6 cycles.
  - Expect pc=0, retired=0 and registers 0 on the next cycle.
  - The program then reruns to identical final state.
- Width: XLEN=16; ADDI R1,R0,300; MUL R2,R1,R1; HLT.
  - Expect R2 = 90000 mod 65536 = 24464.
  - Invalid opcode 0x3E halts identically to HLT.
